// File: rtl/ex_unit.sv
// Integer execute stage: RV32I ALU, branch, JAL/JALR, LUI and AUIPC evaluation.
// Latency: 1 cycle. Every output is registered and appears the cycle after issue.
// No backpressure: one op per cycle is accepted. rdy=0 freezes all state; jump_wrong_stall drops the op.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), jump_wrong_stall (flush)
//   ALU_flag / ALU_V1 / ALU_V2 / ALU_A / ALU_inst_pc / ALU_inst_code / ALU_inst_rob_id : issued op
//   ex_cdb_flag / ex_cdb_rob_id / ex_cdb_val : result broadcast to RS, LSB and ROB
//   ex_br_flag / ex_br_taken / ex_br_target  : branch/jump resolution to the ROB
module ex_unit #(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_wrong_stall,
    input  logic               ALU_flag,
    input  logic [XLEN-1:0]    ALU_V1,
    input  logic [XLEN-1:0]    ALU_V2,
    input  logic [XLEN-1:0]    ALU_A,
    input  logic [XLEN-1:0]    ALU_inst_pc,
    input  logic [5:0]         ALU_inst_code,
    input  logic [ROBID_W-1:0] ALU_inst_rob_id,
    output logic               ex_cdb_flag,
    output logic [ROBID_W-1:0] ex_cdb_rob_id,
    output logic [XLEN-1:0]    ex_cdb_val,
    output logic               ex_br_flag,
    output logic               ex_br_taken,
    output logic [XLEN-1:0]    ex_br_target
);

    // Op codes shared with the decoder.
    localparam logic [5:0] OP_LUI   = 6'd0;
    localparam logic [5:0] OP_AUIPC = 6'd1;
    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SLTI  = 6'd11;
    localparam logic [5:0] OP_SLTIU = 6'd12;
    localparam logic [5:0] OP_XORI  = 6'd13;
    localparam logic [5:0] OP_ORI   = 6'd14;
    localparam logic [5:0] OP_ANDI  = 6'd15;
    localparam logic [5:0] OP_SLLI  = 6'd16;
    localparam logic [5:0] OP_SRLI  = 6'd17;
    localparam logic [5:0] OP_SRAI  = 6'd18;
    localparam logic [5:0] OP_ADD   = 6'd19;
    localparam logic [5:0] OP_SUB   = 6'd20;
    localparam logic [5:0] OP_SLL   = 6'd21;
    localparam logic [5:0] OP_SLT   = 6'd22;
    localparam logic [5:0] OP_SLTU  = 6'd23;
    localparam logic [5:0] OP_XOR   = 6'd24;
    localparam logic [5:0] OP_SRL   = 6'd25;
    localparam logic [5:0] OP_SRA   = 6'd26;
    localparam logic [5:0] OP_OR    = 6'd27;
    localparam logic [5:0] OP_AND   = 6'd28;

    logic [XLEN-1:0] res_val;
    logic            res_br;
    logic            res_taken;
    logic [XLEN-1:0] res_target;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_a;
    logic [XLEN-1:0] jalr_sum;
    logic [4:0]      shamt_r;
    logic [4:0]      shamt_i;
    logic            lt_s_rr;
    logic            lt_u_rr;
    logic            lt_s_ri;
    logic            lt_u_ri;

    assign pc_plus4  = ALU_inst_pc + XLEN'(4);
    assign pc_plus_a = ALU_inst_pc + ALU_A;
    assign jalr_sum  = ALU_V1 + ALU_A;
    assign shamt_r   = ALU_V2[4:0];
    assign shamt_i   = ALU_A[4:0];
    assign lt_s_rr   = $signed(ALU_V1) < $signed(ALU_V2);
    assign lt_u_rr   = ALU_V1 < ALU_V2;
    assign lt_s_ri   = $signed(ALU_V1) < $signed(ALU_A);
    assign lt_u_ri   = ALU_V1 < ALU_A;

    always_comb begin
        res_val    = '0;
        res_br     = 1'b0;
        res_taken  = 1'b0;
        res_target = pc_plus_a;
        case (ALU_inst_code)
            OP_LUI:   res_val = ALU_A;
            OP_AUIPC: res_val = pc_plus_a;
            OP_JAL: begin
                res_val   = pc_plus4;
                res_br    = 1'b1;
                res_taken = 1'b1;
            end
            OP_JALR: begin
                res_val    = pc_plus4;
                res_br     = 1'b1;
                res_taken  = 1'b1;
                res_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BEQ:  begin res_br = 1'b1; res_taken = (ALU_V1 == ALU_V2); end
            OP_BNE:  begin res_br = 1'b1; res_taken = (ALU_V1 != ALU_V2); end
            OP_BLT:  begin res_br = 1'b1; res_taken = lt_s_rr;  end
            OP_BGE:  begin res_br = 1'b1; res_taken = !lt_s_rr; end
            OP_BLTU: begin res_br = 1'b1; res_taken = lt_u_rr;  end
            OP_BGEU: begin res_br = 1'b1; res_taken = !lt_u_rr; end
            OP_ADDI:  res_val = ALU_V1 + ALU_A;
            OP_SLTI:  res_val = XLEN'(lt_s_ri);
            OP_SLTIU: res_val = XLEN'(lt_u_ri);
            OP_XORI:  res_val = ALU_V1 ^ ALU_A;
            OP_ORI:   res_val = ALU_V1 | ALU_A;
            OP_ANDI:  res_val = ALU_V1 & ALU_A;
            OP_SLLI:  res_val = ALU_V1 << shamt_i;
            OP_SRLI:  res_val = ALU_V1 >> shamt_i;
            OP_SRAI:  res_val = $unsigned($signed(ALU_V1) >>> shamt_i);
            OP_ADD:   res_val = ALU_V1 + ALU_V2;
            OP_SUB:   res_val = ALU_V1 - ALU_V2;
            OP_SLL:   res_val = ALU_V1 << shamt_r;
            OP_SLT:   res_val = XLEN'(lt_s_rr);
            OP_SLTU:  res_val = XLEN'(lt_u_rr);
            OP_XOR:   res_val = ALU_V1 ^ ALU_V2;
            OP_SRL:   res_val = ALU_V1 >> shamt_r;
            OP_SRA:   res_val = $unsigned($signed(ALU_V1) >>> shamt_r);
            OP_OR:    res_val = ALU_V1 | ALU_V2;
            OP_AND:   res_val = ALU_V1 & ALU_V2;
            // Unrecognised codes still complete with value 0 so the ROB keeps retiring.
            default:  res_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_cdb_flag   <= 1'b0;
            ex_cdb_rob_id <= '0;
            ex_cdb_val    <= '0;
            ex_br_flag    <= 1'b0;
            ex_br_taken   <= 1'b0;
            ex_br_target  <= '0;
        end else if (jump_wrong_stall) begin
            // Kill pulses only; data registers keep stale contents.
            ex_cdb_flag <= 1'b0;
            ex_br_flag  <= 1'b0;
        end else if (rdy) begin
            ex_cdb_flag <= ALU_flag;
            ex_br_flag  <= ALU_flag && res_br;
            if (ALU_flag) begin
                ex_cdb_rob_id <= ALU_inst_rob_id;
                ex_cdb_val    <= res_val;
                // Resolve fields only change when a branch/jump resolves.
                if (res_br) begin
                    ex_br_taken  <= res_taken;
                    ex_br_target <= res_target;
                end
            end
        end
    end

endmodule
